edge_detect_multi: RTL and testbench

//  - Multi-channel, parametrised Moore edge detector; successor to the single-channel level->tick detector.
//  - Per channel: optional input synchroniser, selectable edge mode (rise/fall/both/off),
//    one-cycle tick with edge direction.
//  - Sits between asynchronous inputs (buttons, status lines) and control FSMs that need single-cycle events.

---
 rtl/edge_detect_multi.sv | 142 ++++++++++++++
 tb/tb_edge_detect_multi.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/edge_detect_multi.sv
// edge_detect_multi: per-channel synchroniser, optional glitch filter and
// Moore edge FSM that turns level changes into one-cycle ticks.
//
// Ports:
//   clk       single clock, rising-edge flops
//   reset_n   asynchronous active-low reset
//   level     raw input levels, one bit per channel
//   mode      per-channel 2-bit mode: 00 off, 01 rise, 10 fall, 11 both
//   tick      one-cycle edge event per channel
//   edge_dir  1 = rising, 0 = falling (valid while tick is high)
//   any_tick  OR of tick
//   level_q   conditioned level that each FSM tracks
//
// Build option: define GLITCH_FILTER_EN to insert a per-channel
// stability filter of FILT_CYCLES cycles between the synchroniser and the FSM.
module edge_detect_multi #(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [CH-1:0]   level,
    input  logic [2*CH-1:0] mode,
    output logic [CH-1:0]   tick,
    output logic [CH-1:0]   edge_dir,
    output logic            any_tick,
    output logic [CH-1:0]   level_q
);

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        RISE = 2'd1,
        ONE  = 2'd2,
        FALL = 2'd3
    } state_t;

    generate
        if (CH < 1) begin : g_bad_ch
            $error("edge_detect_multi: CH must be >= 1");
        end
        if (FILT_CYCLES < 1) begin : g_bad_filt
            $error("edge_detect_multi: FILT_CYCLES must be >= 1");
        end
    endgenerate

    // Synchroniser: s is level delayed by SYNC_STAGES flops.
    logic [CH-1:0] s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = level;
        end else begin : g_sync
            logic [CH-1:0] chain [SYNC_STAGES];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int k = 0; k < SYNC_STAGES; k++) begin
                        chain[k] <= '0;
                    end
                end else begin
                    chain[0] <= level;
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        chain[k] <= chain[k-1];
                    end
                end
            end

            assign s = chain[SYNC_STAGES-1];
        end
    endgenerate

`ifdef GLITCH_FILTER_EN
    // The filtered level only follows s once s has disagreed with it for
    // FILT_CYCLES consecutive samples; any agreement restarts the count.
    localparam int CW = $clog2(FILT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

    logic [CW-1:0] cnt [CH];
    logic [CH-1:0] filt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt <= '0;
            for (int i = 0; i < CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (s[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    filt[i] <= s[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    assign level_q = filt;
`else
    assign level_q = s;
`endif

    // Per-channel Moore FSM. RISE and FALL each last exactly one cycle,
    // which is what makes the tick a single-cycle pulse.
    state_t st [CH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CH; i++) begin
                st[i] <= ZERO;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                case (st[i])
                    ZERO:    st[i] <= level_q[i] ? RISE : ZERO;
                    RISE:    st[i] <= level_q[i] ? ONE  : FALL;
                    ONE:     st[i] <= level_q[i] ? ONE  : FALL;
                    FALL:    st[i] <= level_q[i] ? RISE : ZERO;
                    default: st[i] <= ZERO;
                endcase
            end
        end
    end

    // Mode gates the outputs only, so changing it never disturbs tracking.
    always_comb begin
        tick     = '0;
        edge_dir = '0;
        for (int i = 0; i < CH; i++) begin
            edge_dir[i] = (st[i] == RISE);
            tick[i]     = ((st[i] == RISE) && mode[2*i])
                       || ((st[i] == FALL) && mode[2*i+1]);
        end
    end

    assign any_tick = |tick;

endmodule

// File: tb/tb_edge_detect_multi.sv
// tb_edge_detect_multi: directed testbench for edge_detect_multi
// (CH=4, SYNC_STAGES=2, FILT_CYCLES=8).
module tb_edge_detect_multi;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] level;
    logic [7:0] mode;
    logic [3:0] tick;
    logic [3:0] edge_dir;
    logic       any_tick;
    logic [3:0] level_q;

    int total = 0;
    int bad   = 0;

    edge_detect_multi #(
        .CH(4),
        .SYNC_STAGES(2),
        .FILT_CYCLES(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .level(level),
        .mode(mode),
        .tick(tick),
        .edge_dir(edge_dir),
        .any_tick(any_tick),
        .level_q(level_q)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        level   = 4'hF;
        mode    = 8'hFF;
        repeat (3) step();
        total++;
        if (tick !== 4'h0 || any_tick !== 1'b0) begin
            bad++;
            $display("FAIL reset_tick: got %h/%b want 0/0", tick, any_tick);
        end
        total++;
        if (level_q !== 4'h0) begin
            bad++;
            $display("FAIL reset_level_q: got %h want 0", level_q);
        end
        reset_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            logic [3:0] exp_t;
            step();
            exp_t = (i == 3) ? 4'hF : 4'h0;
            total++;
            if (tick !== exp_t || any_tick !== (i == 3)) begin
                bad++;
                $display("FAIL release_tick c%0d: got %h/%b want %h",
                         i, tick, any_tick, exp_t);
            end
            if (i == 3) begin
                total++;
                if (edge_dir !== 4'hF) begin
                    bad++;
                    $display("FAIL release_dir: got %h want f", edge_dir);
                end
            end
            if (i == 2) begin
                total++;
                if (level_q !== 4'hF) begin
                    bad++;
                    $display("FAIL release_level_q: got %h want f", level_q);
                end
            end
        end
        mode  = 8'h00;
        level = 4'h0;
        for (int i = 1; i <= 8; i++) begin
            step();
            total++;
            if (tick !== 4'h0) begin
                bad++;
                $display("FAIL mode_off c%0d: got %h want 0", i, tick);
            end
        end
    endtask

    task automatic test_modes();
        mode  = 8'hE4;
        level = 4'hF;
        for (int i = 1; i <= 10; i++) begin
            logic [3:0] exp_t;
            step();
            exp_t = (i == 3) ? 4'b1010 : 4'b0000;
            total++;
            if (tick !== exp_t) begin
                bad++;
                $display("FAIL mode_rise c%0d: got %h want %h", i, tick, exp_t);
            end
            if (i == 3) begin
                total++;
                if ((edge_dir & tick) !== 4'b1010) begin
                    bad++;
                    $display("FAIL mode_rise_dir: got %h want a", edge_dir);
                end
            end
        end
        level = 4'h0;
        for (int i = 1; i <= 10; i++) begin
            logic [3:0] exp_t;
            step();
            exp_t = (i == 3) ? 4'b1100 : 4'b0000;
            total++;
            if (tick !== exp_t) begin
                bad++;
                $display("FAIL mode_fall c%0d: got %h want %h", i, tick, exp_t);
            end
            if (i == 3) begin
                total++;
                if ((edge_dir & tick) !== 4'b0000) begin
                    bad++;
                    $display("FAIL mode_fall_dir: got %h want 0", edge_dir);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        mode  = 8'h03;
        level = 4'h1;
        for (int i = 1; i <= 8; i++) begin
            logic [3:0] exp_t;
            step();
            if (i == 1) level = 4'h0;
            exp_t = (i == 3 || i == 4) ? 4'h1 : 4'h0;
            total++;
            if (tick !== exp_t) begin
                bad++;
                $display("FAIL pulse c%0d: got %h want %h", i, tick, exp_t);
            end
            if (i == 3 || i == 4) begin
                total++;
                if (edge_dir[0] !== (i == 3)) begin
                    bad++;
                    $display("FAIL pulse_dir c%0d: got %b want %b",
                             i, edge_dir[0], (i == 3));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        mode  = 8'h0C;
        level = 4'h2;
        repeat (3) step();
        total++;
        if (tick !== 4'h2) begin
            bad++;
            $display("FAIL async_pre: got %h want 2", tick);
        end
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (tick !== 4'h0 || any_tick !== 1'b0) begin
            bad++;
            $display("FAIL async_drop: got %h/%b want 0/0", tick, any_tick);
        end
        level = 4'h0;
        repeat (2) step();
        reset_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            total++;
            if (tick !== 4'h0) begin
                bad++;
                $display("FAIL async_after c%0d: got %h want 0", i, tick);
            end
        end
    endtask

`ifdef GLITCH_FILTER_EN
    task automatic test_filter();
        mode  = 8'h03;
        level = 4'h1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 7) level = 4'h0;
            total++;
            if (tick !== 4'h0) begin
                bad++;
                $display("FAIL filt_glitch c%0d: got %h want 0", i, tick);
            end
        end
        level = 4'h1;
        for (int i = 1; i <= 25; i++) begin
            logic [3:0] exp_t;
            step();
            if (i == 9) level = 4'h0;
            exp_t = (i == 11 || i == 20) ? 4'h1 : 4'h0;
            total++;
            if (tick !== exp_t) begin
                bad++;
                $display("FAIL filt_pass c%0d: got %h want %h", i, tick, exp_t);
            end
            if (i == 11 || i == 20) begin
                total++;
                if (edge_dir[0] !== (i == 11)) begin
                    bad++;
                    $display("FAIL filt_dir c%0d: got %b want %b",
                             i, edge_dir[0], (i == 11));
                end
            end
        end
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        level   = 4'h0;
        mode    = 8'h00;
        test_reset();
        test_modes();
        test_back_to_back();
        test_async_reset();
`ifdef GLITCH_FILTER_EN
        test_filter();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
